johnson_step_gen: RTL and testbench
===================================

# johnson_step_gen

Johnson-code sequence generator feeding the `johnson_to_gray` converter. It produces the 4-bit Johnson word `j` consumed by that stage and advances one code per prescaled tick, forward or backward. It supports synchronous load with illegal-code rejection, and emits step/wrap pulses and a position index used to cross-check the converter's Gray output.

## Interface
- `PRESCALE`, default 1: number of enabled clock cycles per step; legal range 1..256.
- `INIT`, default 4'b0000: Johnson code after reset; must be one of the 8 legal codes.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `en`  in  1  count enable; prescaler advances only while high.
- `dir`  in  1  0 = forward, 1 = backward.
- `load`  in  1  synchronous load request.
- `load_val`  in  4  code to load.
- `clr_err`  in  1  clears sticky `err`.
- `j`  out  4  current Johnson code (registered); drives `johnson_to_gray.j`.
- `pos`  out  3  index of `j` in the forward sequence, 0..7 (registered).
- `step`  out  1  one-cycle pulse; `j` changed this cycle.
- `wrap`  out  1  one-cycle pulse; `j` became 4'b0000 by stepping.
- `err`  out  1  sticky flag; an illegal `load_val` was rejected.

## Operation
- **Legal sequence (pos 0..7):** 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. All other 8 codes are illegal.
- **Forward step:** `j <= {j[2:0], ~j[3]}`, `pos <= pos+1` (mod 8).
- **Backward step:** `j <= {~j[0], j[3:1]}`, `pos <= pos-1` (mod 8).
- **Prescaler:** `pcnt` runs 0..PRESCALE-1.
  - When `en`=1 and `pcnt`==PRESCALE-1: take a step and set `pcnt` to 0.
  - Otherwise, `en`=1 increments `pcnt`; `en`=0 holds it.
  - PRESCALE=1 steps on every enabled cycle.
- **Direction:** `dir` is sampled on the step cycle only. A change mid-count does not reset `pcnt`.
- **Priority per cycle:** reset > load > step.
- **Legal load:** `j <= load_val`, `pos <=` its index, `pcnt <= 0`. No step and no wrap that cycle, regardless of `en`.
- **Illegal load:** `j <= 4'b0000`, `pos <= 0`, `pcnt <= 0`, `err <= 1`. `step`/`wrap` stay low.
- **err:** set by an illegal load, cleared by `clr_err`. If both happen in the same cycle, set wins.
- **wrap:** asserted with `step` when the new `j` is 0000, i.e. forward from 1000 or backward from 0001.
- **Invariant:** `j` is never illegal. The bench asserts this every cycle.

## Timing
- **Reset values:** `j`=INIT, `pos`=index(INIT), `pcnt`=0, `step`=0, `wrap`=0, `err`=0.
- **Reset mid-operation:** a reset cycle overrides everything, including a pending step or load.
- **Output registers:** all outputs are registered. `step`/`wrap` are high in the same cycle the new `j` is visible, and low otherwise.
- **Load latency:** a load sampled at edge N shows `load_val` (or 0000) on `j` after edge N.
- **Step latency:**
  - With `en` held high continuously from reset, the first step appears after edge PRESCALE.
  - Thereafter steps come every PRESCALE cycles.
- **Prescaler during enable gaps:** deasserting `en` stretches the interval by the number of low cycles.
- **Downstream timing:** the converter output `g` is combinational from `j`. It is valid in the same cycle as `step`.
- **Synthesis rule:** no combinational path from any input to any output.

## Test plan
- **Forward run:** PRESCALE=1, INIT=0000, reset, then `en`=1, `dir`=0 for 9 cycles.
  - `j` = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; `pos` = 1..7, 0, 1.
  - `step` high every cycle; `wrap` high only on the 0000 cycle.
  - Converter `g` = 001, 011, 010, 110, 111, 101, 100, 000, 001.
- **Backward with direction flip:** from `j`=0000, `dir`=1, 2 steps.
  - `j` = 1000 (with no wrap), then 1100, `pos`=7, 6.
  - Then `dir`=0 for 1 step gives 1000 (`pos` 7); 1 more step gives 0000 with `wrap`=1.
- **Prescale with enable gap:** PRESCALE=3, `en`=1 for 2 cycles, 0 for 4 cycles, 1 again.
  - The first step occurs on the 1st cycle after `en` returns.
  - The next step occurs exactly 3 enabled cycles later.
- **Load priority:** `en`=1 and step due, `load`=1, `load_val`=0111.
  - `j`=0111, `pos`=3, `step`=0.
  - The next step (PRESCALE=1, `dir`=0) gives 1111.
- **Illegal load and err:** `load_val`=0101 gives `j`=0000, `pos`=0, `err`=1.
  - `err` stays 1 across 10 steps.
  - `clr_err` together with another illegal load (1010) keeps `err`=1.
  - `clr_err` alone clears it to 0.
- **Reset mid-run:** INIT=1110, reset asserted while `load` and a step are both pending.
  - The next cycle shows `j`=1110, `pos`=5, `step`=0, `wrap`=0, `err`=0.
  - The first step comes PRESCALE enabled cycles after `rst_n` rises.

Source files
------------

// File: rtl/johnson_step_gen.sv
`timescale 1ns/1ps
// johnson_step_gen
//   Four-bit Johnson counter with prescaler, run direction, synchronous load
//   that rejects illegal codes, and step/wrap pulses. This file also holds the
//   downstream johnson_to_gray converter, which is combinational from j.
//
//   Parameters
//     PRESCALE  enabled clock cycles per step, 1..256
//     INIT      Johnson code after reset (must be one of the 8 legal codes)
//   Ports
//     clk       rising-edge clock
//     rst_n     synchronous active-low reset
//     en        count enable; the prescaler advances only while high
//     dir       0 = forward, 1 = backward; sampled on the step cycle only
//     load      synchronous load request; takes priority over a step
//     load_val  code to load; an illegal code loads 0000 and sets err
//     clr_err   clears the sticky err flag; an illegal load in the same cycle wins
//     j         current Johnson code (registered)
//     pos       index of j in the forward sequence, 0..7 (registered)
//     step      one-cycle pulse, j changed by stepping this cycle
//     wrap      one-cycle pulse, j became 0000 by stepping
//     err       sticky illegal-load flag

module johnson_to_gray (
   input  logic [3:0] j,
   output logic [2:0] g
);
   // Gray of the sequence index: the MSB is the Johnson MSB, the middle bit
   // is high for positions 2..5 (exactly when j[1] is set), and the LSB is
   // high for positions 1,2,5,6 (exactly when j[2] and j[0] differ).
   assign g = {j[3], j[1], j[2] ^ j[0]};
endmodule

module johnson_step_gen #(
   parameter int         PRESCALE = 1,
   parameter logic [3:0] INIT     = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       dir,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       clr_err,
   output logic [3:0] j,
   output logic [2:0] pos,
   output logic       step,
   output logic       wrap,
   output logic       err
);

   localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PCW-1:0] PMAX = PCW'(PRESCALE - 1);

   // Returns {legal, index}. Illegal codes report index 0, which is also the
   // position of the 0000 fallback an illegal load installs.
   function automatic logic [3:0] legal_idx(input logic [3:0] c);
      logic [3:0] r;
      case (c)
         4'b0000: r = 4'b1_000;
         4'b0001: r = 4'b1_001;
         4'b0011: r = 4'b1_010;
         4'b0111: r = 4'b1_011;
         4'b1111: r = 4'b1_100;
         4'b1110: r = 4'b1_101;
         4'b1100: r = 4'b1_110;
         4'b1000: r = 4'b1_111;
         default: r = 4'b0_000;
      endcase
      return r;
   endfunction

   localparam logic [3:0] INIT_LI  = legal_idx(INIT);
   localparam logic [2:0] INIT_POS = INIT_LI[2:0];

   logic [PCW-1:0] pcnt, pcnt_nxt;
   logic [3:0]     j_nxt, j_step, load_li;
   logic [2:0]     pos_nxt, pos_step;
   logic           step_nxt, wrap_nxt, err_nxt;
   logic           step_due, load_ok;

   assign load_li  = legal_idx(load_val);
   assign load_ok  = load_li[3];
   assign step_due = en && (pcnt == PMAX);

   // Shift left inserting ~MSB (forward) or shift right inserting ~LSB
   // (backward); both preserve Johnson legality.
   assign j_step   = dir ? {~j[0], j[3:1]} : {j[2:0], ~j[3]};
   assign pos_step = dir ? (pos - 3'd1) : (pos + 3'd1);

   always_comb begin
      j_nxt    = j;
      pos_nxt  = pos;
      pcnt_nxt = pcnt;
      step_nxt = 1'b0;
      wrap_nxt = 1'b0;
      err_nxt  = err;

      if (load) begin
         // A load always restarts the prescale interval and suppresses the
         // step that may have been due in the same cycle.
         pcnt_nxt = '0;
         if (load_ok) begin
            j_nxt   = load_val;
            pos_nxt = load_li[2:0];
         end else begin
            j_nxt   = 4'b0000;
            pos_nxt = 3'd0;
         end
      end else if (step_due) begin
         pcnt_nxt = '0;
         j_nxt    = j_step;
         pos_nxt  = pos_step;
         step_nxt = 1'b1;
         wrap_nxt = (j_step == 4'b0000);
      end else if (en) begin
         pcnt_nxt = pcnt + PCW'(1);
      end

      // Set beats clear when both occur together.
      if (load && !load_ok)
         err_nxt = 1'b1;
      else if (clr_err)
         err_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         j    <= INIT;
         pos  <= INIT_POS;
         pcnt <= '0;
         step <= 1'b0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         j    <= j_nxt;
         pos  <= pos_nxt;
         pcnt <= pcnt_nxt;
         step <= step_nxt;
         wrap <= wrap_nxt;
         err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_johnson_step_gen.sv
`timescale 1ns/1ps
// Directed bench for johnson_step_gen. Three instances share the inputs:
// a (PRESCALE=1, INIT=0000) with the Gray converter on its output,
// b (PRESCALE=3, INIT=0000) for prescale gaps, c (PRESCALE=2, INIT=1110)
// for reset-to-INIT behaviour.
module tb_johnson_step_gen;

   logic       clk = 1'b0;
   logic       rst_n, en, dir, load, clr_err;
   logic [3:0] load_val;

   logic [3:0] j_a, j_b, j_c;
   logic [2:0] pos_a, pos_b, pos_c, g_a;
   logic       step_a, step_b, step_c, wrap_a, wrap_b, wrap_c, err_a, err_b, err_c;

   int n_tests = 0;
   int n_fail  = 0;
   bit inv_on  = 1'b0;

   always #5 clk = ~clk;

   johnson_step_gen #(.PRESCALE(1), .INIT(4'b0000)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr_err(clr_err), .j(j_a), .pos(pos_a), .step(step_a), .wrap(wrap_a), .err(err_a));
   johnson_step_gen #(.PRESCALE(3), .INIT(4'b0000)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr_err(clr_err), .j(j_b), .pos(pos_b), .step(step_b), .wrap(wrap_b), .err(err_b));
   johnson_step_gen #(.PRESCALE(2), .INIT(4'b1110)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .clr_err(clr_err), .j(j_c), .pos(pos_c), .step(step_c), .wrap(wrap_c), .err(err_c));
   johnson_to_gray u_g (.j(j_a), .g(g_a));

   function automatic bit is_legal(input logic [3:0] c);
      case (c)
         4'b0000, 4'b0001, 4'b0011, 4'b0111,
         4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // j must never hold an illegal code on any instance.
   always @(negedge clk) begin
      if (inv_on) begin
         n_tests++;
         assert ((is_legal(j_a) && is_legal(j_b) && is_legal(j_c)) === 1'b1) else begin
            n_fail++;
            $error("FAIL invariant: got j_a=%b j_b=%b j_c=%b expected legal codes", j_a, j_b, j_c);
         end
      end
   end

   logic [3:0] fj [9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
   logic [2:0] fp [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
   logic [2:0] fg [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};

   initial begin
      rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'h0; clr_err = 1'b0;

      // ---- reset state
      tick();
      inv_on = 1'b1;
      chk("rst_j_a",    8'(j_a),    8'h00);
      chk("rst_pos_a",  8'(pos_a),  8'h00);
      chk("rst_step_a", 8'(step_a), 8'h00);
      chk("rst_wrap_a", 8'(wrap_a), 8'h00);
      chk("rst_err_a",  8'(err_a),  8'h00);
      chk("rst_j_c",    8'(j_c),    8'h0E);
      chk("rst_pos_c",  8'(pos_c),  8'h05);

      // ---- forward run, PRESCALE=1
      rst_n = 1'b1; en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("fwd_j_%0d", i),    8'(j_a),    8'(fj[i]));
         chk($sformatf("fwd_pos_%0d", i),  8'(pos_a),  8'(fp[i]));
         chk($sformatf("fwd_step_%0d", i), 8'(step_a), 8'h01);
         chk($sformatf("fwd_wrap_%0d", i), 8'(wrap_a), (i == 7) ? 8'h01 : 8'h00);
         chk($sformatf("fwd_g_%0d", i),    8'(g_a),    8'(fg[i]));
      end

      // ---- backward with direction flip, from 0000
      rst_n = 1'b0; en = 1'b0;
      tick();
      rst_n = 1'b1; en = 1'b1; dir = 1'b1;
      tick();
      chk("bwd1_j",    8'(j_a),    8'h08);
      chk("bwd1_pos",  8'(pos_a),  8'h07);
      chk("bwd1_wrap", 8'(wrap_a), 8'h00);
      tick();
      chk("bwd2_j",    8'(j_a),    8'h0C);
      chk("bwd2_pos",  8'(pos_a),  8'h06);
      dir = 1'b0;
      tick();
      chk("flip1_j",   8'(j_a),    8'h08);
      chk("flip1_pos", 8'(pos_a),  8'h07);
      chk("flip1_wrap",8'(wrap_a), 8'h00);
      tick();
      chk("flip2_j",   8'(j_a),    8'h00);
      chk("flip2_wrap",8'(wrap_a), 8'h01);
      chk("flip2_step",8'(step_a), 8'h01);

      // ---- prescale with enable gap, instance b (PRESCALE=3)
      rst_n = 1'b0; en = 1'b0;
      tick();
      rst_n = 1'b1; en = 1'b1;
      tick(); chk("pre_en1_step", 8'(step_b), 8'h00);
      tick(); chk("pre_en2_step", 8'(step_b), 8'h00);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("pre_gap%0d_step", i), 8'(step_b), 8'h00);
         chk($sformatf("pre_gap%0d_j", i),    8'(j_b),    8'h00);
      end
      en = 1'b1;
      tick();
      chk("pre_first_step", 8'(step_b), 8'h01);
      chk("pre_first_j",    8'(j_b),    8'h01);
      tick(); chk("pre_mid1_step", 8'(step_b), 8'h00);
      tick(); chk("pre_mid2_step", 8'(step_b), 8'h00);
      tick();
      chk("pre_second_step", 8'(step_b), 8'h01);
      chk("pre_second_j",    8'(j_b),    8'h03);
      chk("pre_second_pos",  8'(pos_b),  8'h02);

      // ---- load priority over a due step, instance a
      load = 1'b1; load_val = 4'b0111;
      tick();
      chk("ld_j",    8'(j_a),    8'h07);
      chk("ld_pos",  8'(pos_a),  8'h03);
      chk("ld_step", 8'(step_a), 8'h00);
      load = 1'b0;
      tick();
      chk("ld_next_j",    8'(j_a),    8'h0F);
      chk("ld_next_step", 8'(step_a), 8'h01);
      load = 1'b1; load_val = 4'b1000;
      tick();
      chk("ld8_j",    8'(j_a),    8'h08);
      chk("ld8_pos",  8'(pos_a),  8'h07);
      chk("ld8_wrap", 8'(wrap_a), 8'h00);
      load = 1'b0;
      tick();
      chk("ld8_next_j",    8'(j_a),    8'h00);
      chk("ld8_next_wrap", 8'(wrap_a), 8'h01);

      // ---- illegal load and sticky err
      load = 1'b1; load_val = 4'b0101;
      tick();
      chk("ill_j",    8'(j_a),    8'h00);
      chk("ill_pos",  8'(pos_a),  8'h00);
      chk("ill_err",  8'(err_a),  8'h01);
      chk("ill_step", 8'(step_a), 8'h00);
      load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("ill_hold%0d_err", i),  8'(err_a),  8'h01);
         chk($sformatf("ill_hold%0d_step", i), 8'(step_a), 8'h01);
      end
      chk("ill_run_j",   8'(j_a),   8'h03);
      chk("ill_run_pos", 8'(pos_a), 8'h02);
      clr_err = 1'b1; load = 1'b1; load_val = 4'b1010;
      tick();
      chk("clr_vs_set_err", 8'(err_a), 8'h01);
      chk("clr_vs_set_j",   8'(j_a),   8'h00);
      load = 1'b0;
      tick();
      chk("clr_err", 8'(err_a), 8'h00);
      clr_err = 1'b0;

      // ---- reset mid-run on instance c (PRESCALE=2, INIT=1110)
      load = 1'b1; load_val = 4'b0100;
      tick();
      chk("mr_ill_err_c", 8'(err_c), 8'h01);
      chk("mr_ill_j_c",   8'(j_c),   8'h00);
      load = 1'b0;
      tick();
      chk("mr_pend_step_c", 8'(step_c), 8'h00);
      // step now due on c; assert reset together with a load
      rst_n = 1'b0; load = 1'b1; load_val = 4'b0011;
      tick();
      chk("mr_rst_j_c",    8'(j_c),    8'h0E);
      chk("mr_rst_pos_c",  8'(pos_c),  8'h05);
      chk("mr_rst_step_c", 8'(step_c), 8'h00);
      chk("mr_rst_wrap_c", 8'(wrap_c), 8'h00);
      chk("mr_rst_err_c",  8'(err_c),  8'h00);
      rst_n = 1'b1; load = 1'b0;
      tick();
      chk("mr_post1_step_c", 8'(step_c), 8'h00);
      chk("mr_post1_j_c",    8'(j_c),    8'h0E);
      tick();
      chk("mr_post2_step_c", 8'(step_c), 8'h01);
      chk("mr_post2_j_c",    8'(j_c),    8'h0C);
      chk("mr_post2_pos_c",  8'(pos_c),  8'h06);

      en = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
